// File: rtl/config_uart_pkg.sv
// config_uart_pkg: shared types and framing constants; frame grows when CONFIG_UART_TX_PARITY_EN is defined
package config_uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;
`ifdef CONFIG_UART_TX_PARITY_EN
    localparam int FRAME_BITS     = 11;
`else
    localparam int FRAME_BITS     = 10;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef CONFIG_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

endpackage

// File: rtl/config_uart_tx_timer.sv
// uart_bit_timer: per-bit down-counter producing a one-cycle bit_done pulse, re-armed on every boundary
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic CLK,
    input  logic resetn,
    input  logic i_restart,
    output logic o_bit_done
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_cnt;

    // reload on accept or at each bit boundary so bit lengths never accumulate error
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)
            r_cnt <= 16'd0;
        else if (i_restart || r_cnt == 16'd0)
            r_cnt <= RELOAD;
        else
            r_cnt <= r_cnt - 16'd1;
    end

    assign o_bit_done = (r_cnt == 16'd0);

endmodule

// File: rtl/config_uart_tx.sv
// config_uart_tx: 32-bit word to four UART frames, MSB byte first; CONFIG_UART_TX_PARITY_EN adds even parity
import config_uart_pkg::*;

module config_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        Tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    state_t      r_state;
    logic [31:0] r_shift;
    logic [1:0]  r_byte;
    logic [2:0]  r_bit;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;
    logic [15:0] r_sent;

    logic        w_accept;
    logic        w_bit_done;
    logic [7:0]  w_cur_byte;
    logic [2:0]  w_next_bit;

    assign w_accept   = word_valid && r_ready;
    assign w_cur_byte = r_shift[31:24];
    assign w_next_bit = r_bit + 3'd1;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .CLK        (CLK),
        .resetn     (resetn),
        .i_restart  (w_accept),
        .o_bit_done (w_bit_done)
    );

    // framing FSM: line level, handshake and word count are all registered here
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_shift <= 32'd0;
            r_byte  <= 2'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_sent  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= word_data;
                        r_byte  <= 2'd0;
                        r_bit   <= 3'd0;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_bit   <= 3'd0;
                        r_tx    <= w_cur_byte[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef CONFIG_UART_TX_PARITY_EN
                            r_tx    <= ^w_cur_byte;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= w_next_bit;
                            r_tx  <= w_cur_byte[w_next_bit];
                        end
                    end
                end
`ifdef CONFIG_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_done) begin
                        if (r_byte == 2'(BYTES_PER_WORD - 1)) begin
                            r_sent  <= r_sent + 16'd1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_shift <= {r_shift[23:0], 8'h00};
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign word_ready = r_ready;
    assign busy       = r_busy;
    assign Tx         = r_tx;
    assign words_sent = r_sent;

endmodule
